// File: rtl/snake_pkg.sv
// Shared snake-game constants: coordinate widths, playfield bounds, fallback food spot,
// and the food spawner state encoding.
package snake_pkg;

  localparam int X_W  = 10;
  localparam int Y_W  = 9;
  localparam int GRID = 10;

  localparam int X_MIN = 20;
  localparam int X_MAX = 620;
  localparam int Y_MIN = 20;
  localparam int Y_MAX = 460;

  localparam int FALLBACK_X_DEF = 320;
  localparam int FALLBACK_Y_DEF = 240;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SCAN,
    ST_COMMIT,
    ST_FALLBACK
  } food_state_t;

  function automatic logic [X_W-1:0] clamp_x(input logic [X_W-1:0] v);
    if (v < X_W'(X_MIN)) return X_W'(X_MIN);
    if (v > X_W'(X_MAX)) return X_W'(X_MAX);
    return v;
  endfunction

  function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] v);
    if (v < Y_W'(Y_MIN)) return Y_W'(Y_MIN);
    if (v > Y_W'(Y_MAX)) return Y_W'(Y_MAX);
    return v;
  endfunction

endpackage

// File: rtl/seg_overlap.sv
// Combinational GRID x GRID block-overlap test between a candidate point and a segment.
// Shared with the eat and self-collision detectors.
module seg_overlap
  import snake_pkg::*;
(
  input  logic [X_W-1:0] cand_x_i,
  input  logic [Y_W-1:0] cand_y_i,
  input  logic [X_W-1:0] seg_x_i,
  input  logic [Y_W-1:0] seg_y_i,
  output logic           overlap_o
);

  logic [X_W:0] dx_raw;
  logic [X_W:0] dx_abs;
  logic [Y_W:0] dy_raw;
  logic [Y_W:0] dy_abs;

  // One extra bit keeps the borrow, so the top bit acts as the sign of the difference.
  always_comb begin
    dx_raw    = {1'b0, seg_x_i} - {1'b0, cand_x_i};
    dy_raw    = {1'b0, seg_y_i} - {1'b0, cand_y_i};
    dx_abs    = dx_raw[X_W] ? (~dx_raw + 1'b1) : dx_raw;
    dy_abs    = dy_raw[Y_W] ? (~dy_raw + 1'b1) : dy_raw;
    overlap_o = (dx_abs < (X_W+1)'(GRID)) && (dy_abs < (Y_W+1)'(GRID));
  end

endmodule

// File: rtl/food_spawn_ctrl.sv
// Food placement sequencer: samples a random point, clamps it to the playfield, scans
// the snake body through the registered segment RAM, retries on overlap, then publishes.
module food_spawn_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_LEN    = 32,
  parameter int ADDR_W     = 5,
  parameter int MAX_TRIES  = 8,
  parameter int FALLBACK_X = FALLBACK_X_DEF,
  parameter int FALLBACK_Y = FALLBACK_Y_DEF
) (
  input  logic              VGA_clk,
  input  logic              reset,
  input  logic              spawn_req,
  input  logic [X_W-1:0]    rand_x,
  input  logic [Y_W-1:0]    rand_y,
  input  logic [ADDR_W:0]   snake_len,
  output logic [ADDR_W-1:0] seg_addr,
  input  logic [X_W-1:0]    seg_x,
  input  logic [Y_W-1:0]    seg_y,
  output logic [X_W-1:0]    food_x,
  output logic [Y_W-1:0]    food_y,
  output logic              food_valid,
  output logic              busy,
  output logic              spawn_done,
  output logic              fallback_used
);

  localparam int              TRY_W   = $clog2(MAX_TRIES + 1);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(MAX_LEN);

  food_state_t      state_q, state_d;
  logic [X_W-1:0]   cand_x_q, cand_x_d;
  logic [Y_W-1:0]   cand_y_q, cand_y_d;
  logic [ADDR_W:0]  len_q, len_d;
  logic [ADDR_W:0]  idx_q, idx_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             cmp_valid_q, cmp_valid_d;
  logic [X_W-1:0]   food_x_q, food_x_d;
  logic [Y_W-1:0]   food_y_q, food_y_d;
  logic             food_valid_q, food_valid_d;
  logic             spawn_done_q, spawn_done_d;
  logic             fallback_q, fallback_d;

  logic             overlap;
  logic [ADDR_W:0]  len_sat;

  seg_overlap u_overlap (
    .cand_x_i  (cand_x_q),
    .cand_y_i  (cand_y_q),
    .seg_x_i   (seg_x),
    .seg_y_i   (seg_y),
    .overlap_o (overlap)
  );

  assign len_sat = (snake_len > LEN_MAX) ? LEN_MAX : snake_len;

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      tries_q      <= '0;
      cmp_valid_q  <= 1'b0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      spawn_done_q <= 1'b0;
      fallback_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      tries_q      <= tries_d;
      cmp_valid_q  <= cmp_valid_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      spawn_done_q <= spawn_done_d;
      fallback_q   <= fallback_d;
    end
  end

  // cmp_valid_q marks that seg_x/seg_y carry the data for index idx_q-1 this cycle;
  // once idx_q reaches len_q a valid compare is the last one of the scan.
  always_comb begin
    state_d      = state_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    len_d        = len_q;
    idx_d        = idx_q;
    tries_d      = tries_q;
    cmp_valid_d  = 1'b0;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    spawn_done_d = 1'b0;
    fallback_d   = fallback_q;

    unique case (state_q)
      ST_IDLE: begin
        if (spawn_req) begin
          state_d      = ST_SAMPLE;
          food_valid_d = 1'b0;
          tries_d      = '0;
        end
      end
      ST_SAMPLE: begin
        cand_x_d = clamp_x(rand_x);
        cand_y_d = clamp_y(rand_y);
        len_d    = len_sat;
        idx_d    = '0;
        tries_d  = tries_q + 1'b1;
        state_d  = (len_sat == '0) ? ST_COMMIT : ST_SCAN;
      end
      ST_SCAN: begin
        if (cmp_valid_q && overlap) begin
          state_d = (tries_q == TRY_W'(MAX_TRIES)) ? ST_FALLBACK : ST_SAMPLE;
        end else if (cmp_valid_q && (idx_q == len_q)) begin
          state_d = ST_COMMIT;
        end else if (idx_q < len_q) begin
          idx_d       = idx_q + 1'b1;
          cmp_valid_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        food_x_d     = cand_x_q;
        food_y_d     = cand_y_q;
        food_valid_d = 1'b1;
        spawn_done_d = 1'b1;
        fallback_d   = 1'b0;
        state_d      = ST_IDLE;
      end
      ST_FALLBACK: begin
        food_x_d     = X_W'(FALLBACK_X);
        food_y_d     = Y_W'(FALLBACK_Y);
        food_valid_d = 1'b1;
        spawn_done_d = 1'b1;
        fallback_d   = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign seg_addr      = idx_q[ADDR_W-1:0];
  assign food_x        = food_x_q;
  assign food_y        = food_y_q;
  assign food_valid    = food_valid_q;
  assign busy          = (state_q != ST_IDLE);
  assign spawn_done    = spawn_done_q;
  assign fallback_used = fallback_q;

endmodule

// File: tb/tb_food_spawn_ctrl.sv
// Self-checking bench for food_spawn_ctrl: directed timing/boundary scenarios plus
// randomized spawns checked against an attempt-level reference model.
module tb_food_spawn_ctrl;

  localparam int MAX_LEN   = 32;
  localparam int ADDR_W    = 5;
  localparam int MAX_TRIES = 8;
  localparam int FX        = 320;
  localparam int FY        = 240;
  localparam int MAXE      = 400;

  logic              VGA_clk;
  logic              reset;
  logic              spawn_req;
  logic [9:0]        rand_x;
  logic [8:0]        rand_y;
  logic [ADDR_W:0]   snake_len;
  logic [ADDR_W-1:0] seg_addr;
  logic [9:0]        seg_x;
  logic [8:0]        seg_y;
  logic [9:0]        food_x;
  logic [8:0]        food_y;
  logic              food_valid;
  logic              busy;
  logic              spawn_done;
  logic              fallback_used;

  int compared;
  int mismatched;

  // Per-edge stimulus tables (index = edges after the spawn_req edge) and segment RAM.
  int rx[MAXE+1];
  int ry[MAXE+1];
  int ln[MAXE+1];
  int memx[MAX_LEN];
  int memy[MAX_LEN];

  food_spawn_ctrl #(
    .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .MAX_TRIES(MAX_TRIES),
    .FALLBACK_X(FX), .FALLBACK_Y(FY)
  ) dut (
    .VGA_clk(VGA_clk), .reset(reset), .spawn_req(spawn_req),
    .rand_x(rand_x), .rand_y(rand_y), .snake_len(snake_len),
    .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .busy(busy), .spawn_done(spawn_done), .fallback_used(fallback_used)
  );

  initial begin
    VGA_clk = 1'b0;
    forever #5 VGA_clk = ~VGA_clk;
  end

  always @(posedge VGA_clk) begin
    seg_x <= 10'(memx[seg_addr]);
    seg_y <= 9'(memy[seg_addr]);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int absd(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  // Attempt-level model: attempt started at edge s takes k+3 edges to fail on index k,
  // len+2 edges to succeed (1 edge when len is 0), and the last failure falls back.
  task automatic predict(output int expEdge, output int ex, output int ey, output bit efb);
    int s, len, cx, cy, k;
    s = 1; expEdge = -1; ex = 0; ey = 0; efb = 1'b0;
    for (int t = 1; t <= MAX_TRIES; t++) begin
      len = (ln[s] > MAX_LEN) ? MAX_LEN : ln[s];
      cx  = clampi(rx[s], 20, 620);
      cy  = clampi(ry[s], 20, 460);
      k   = -1;
      for (int i = 0; i < len; i++)
        if (k < 0 && absd(memx[i], cx) < 10 && absd(memy[i], cy) < 10) k = i;
      if (k < 0) begin
        ex = cx; ey = cy; efb = 1'b0;
        expEdge = (len == 0) ? s + 1 : s + len + 2;
        return;
      end
      if (t == MAX_TRIES) begin
        ex = FX; ey = FY; efb = 1'b1;
        expEdge = s + k + 3;
        return;
      end
      s = s + k + 3;
    end
  endtask

  task automatic fillConst(int x, int y, int l);
    for (int e = 0; e <= MAXE; e++) begin rx[e] = x; ry[e] = y; ln[e] = l; end
  endtask

  task automatic fillMem(int x, int y);
    for (int i = 0; i < MAX_LEN; i++) begin memx[i] = x; memy[i] = y; end
  endtask

  // Drives one spawn edge by edge from the tables and reports what was observed.
  task automatic runSpawn(input bit noise, output int doneEdge, output int fx, output int fy,
                          output bit fb, output bit busyE0, output bit validLowE1, output bit fbE1);
    doneEdge = -1; fx = -1; fy = -1; fb = 1'b0; busyE0 = 1'b0; validLowE1 = 1'b0; fbE1 = 1'b0;
    for (int e = 0; e <= MAXE; e++) begin
      rand_x    = 10'(rx[e]);
      rand_y    = 9'(ry[e]);
      snake_len = 6'(ln[e]);
      spawn_req = (e == 0) ? 1'b1 : (noise ? ($urandom_range(0, 3) == 0) : 1'b0);
      @(posedge VGA_clk); #1;
      if (e == 0) busyE0 = busy;
      if (e == 1) begin validLowE1 = !food_valid; fbE1 = fallback_used; end
      if (spawn_done) begin
        doneEdge = e; fx = food_x; fy = food_y; fb = fallback_used;
        break;
      end
    end
    spawn_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; spawn_req = 1'b0; rand_x = '0; rand_y = '0; snake_len = '0;
    repeat (3) @(posedge VGA_clk);
    #1;
    compared += 7;
    if (food_x !== 10'd0) begin mismatched++; $display("[TB] FAIL reset_food_x: got %0d expected 0", food_x); end
    if (food_y !== 9'd0) begin mismatched++; $display("[TB] FAIL reset_food_y: got %0d expected 0", food_y); end
    if (food_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_food_valid: got %b expected 0", food_valid); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (spawn_done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_spawn_done: got %b expected 0", spawn_done); end
    if (fallback_used !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_fallback: got %b expected 0", fallback_used); end
    if (seg_addr !== 5'd0) begin mismatched++; $display("[TB] FAIL reset_seg_addr: got %0d expected 0", seg_addr); end
    @(negedge VGA_clk); reset = 1'b0;
    @(posedge VGA_clk); #1;
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_len_zero;
    int de, fx, fy; bit fb, b0, v1, f1;
    fillConst(300, 200, 0);
    runSpawn(1'b0, de, fx, fy, fb, b0, v1, f1);
    compared += 6;
    if (de !== 2) begin mismatched++; $display("[TB] FAIL len0_edge: got %0d expected 2", de); end
    if (fx !== 300 || fy !== 200) begin mismatched++; $display("[TB] FAIL len0_food: got (%0d,%0d) expected (300,200)", fx, fy); end
    if (fb !== 1'b0) begin mismatched++; $display("[TB] FAIL len0_fallback: got %b expected 0", fb); end
    if (b0 !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_busy: got %b expected 1", b0); end
    if (v1 !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_valid_low: got %b expected 1", v1); end
    if (food_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL len0_valid: got %b expected 1", food_valid); end
  endtask

  task automatic test_free_scan;
    int de, fx, fy; bit fb, b0, v1, f1;
    fillMem(600, 450);
    memx[0] = 500; memy[0] = 400; memx[1] = 50;  memy[1] = 60;
    memx[2] = 600; memy[2] = 30;  memx[3] = 100; memy[3] = 450;
    fillConst(250, 130, 4);
    runSpawn(1'b0, de, fx, fy, fb, b0, v1, f1);
    compared += 3;
    if (de !== 7) begin mismatched++; $display("[TB] FAIL scan_edge: got %0d expected 7", de); end
    if (fx !== 250 || fy !== 130) begin mismatched++; $display("[TB] FAIL scan_food: got (%0d,%0d) expected (250,130)", fx, fy); end
    if (fb !== 1'b0) begin mismatched++; $display("[TB] FAIL scan_fallback: got %b expected 0", fb); end
  endtask

  task automatic test_clamp;
    int de, fx, fy; bit fb, b0, v1, f1;
    fillConst(5, 500, 0);
    runSpawn(1'b0, de, fx, fy, fb, b0, v1, f1);
    compared++;
    if (fx !== 20 || fy !== 460) begin mismatched++; $display("[TB] FAIL clamp_low_high: got (%0d,%0d) expected (20,460)", fx, fy); end
    fillConst(1000, 3, 0);
    runSpawn(1'b0, de, fx, fy, fb, b0, v1, f1);
    compared++;
    if (fx !== 620 || fy !== 20) begin mismatched++; $display("[TB] FAIL clamp_high_low: got (%0d,%0d) expected (620,20)", fx, fy); end
  endtask

  task automatic test_retry;
    int de, fx, fy; bit fb, b0, v1, f1;
    fillMem(600, 450);
    memx[0] = 500; memy[0] = 400; memx[1] = 50;  memy[1] = 60;
    memx[2] = 253; memy[2] = 135; memx[3] = 100; memy[3] = 450;
    for (int e = 0; e <= MAXE; e++) begin
      rx[e] = $urandom_range(0, 1023); ry[e] = $urandom_range(0, 511); ln[e] = 4;
    end
    rx[1] = 250; ry[1] = 130; rx[6] = 400; ry[6] = 300;
    runSpawn(1'b0, de, fx, fy, fb, b0, v1, f1);
    compared += 2;
    if (de !== 12) begin mismatched++; $display("[TB] FAIL retry_edge: got %0d expected 12", de); end
    if (fx !== 400 || fy !== 300) begin mismatched++; $display("[TB] FAIL retry_food: got (%0d,%0d) expected (400,300)", fx, fy); end
  endtask

  task automatic test_fallback;
    int de, fx, fy; bit fb, b0, v1, f1;
    fillMem(600, 450);
    memx[5] = 105; memy[5] = 98;
    fillConst(100, 100, 10);
    runSpawn(1'b1, de, fx, fy, fb, b0, v1, f1);
    compared += 3;
    if (de !== 65) begin mismatched++; $display("[TB] FAIL fallback_edge: got %0d expected 65", de); end
    if (fx !== FX || fy !== FY) begin mismatched++; $display("[TB] FAIL fallback_food: got (%0d,%0d) expected (%0d,%0d)", fx, fy, FX, FY); end
    if (fb !== 1'b1) begin mismatched++; $display("[TB] FAIL fallback_flag: got %b expected 1", fb); end
    fillConst(300, 200, 0);
    runSpawn(1'b0, de, fx, fy, fb, b0, v1, f1);
    compared += 2;
    if (f1 !== 1'b1) begin mismatched++; $display("[TB] FAIL fallback_hold: got %b expected 1", f1); end
    if (fb !== 1'b0) begin mismatched++; $display("[TB] FAIL fallback_clear: got %b expected 0", fb); end
  endtask

  task automatic test_reset_mid_scan;
    fillMem(600, 450);
    fillConst(200, 200, 8);
    rand_x = 10'd200; rand_y = 9'd200; snake_len = 6'd8;
    spawn_req = 1'b1;
    @(posedge VGA_clk); #1;
    spawn_req = 1'b0;
    repeat (3) @(posedge VGA_clk);
    #1;
    compared += 2;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL midscan_busy: got %b expected 1", busy); end
    if (seg_addr !== 5'd2) begin mismatched++; $display("[TB] FAIL midscan_addr: got %0d expected 2", seg_addr); end
    #2 reset = 1'b1;
    #1;
    compared += 6;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    if (food_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: got %b expected 0", food_valid); end
    if (food_x !== 10'd0 || food_y !== 9'd0) begin mismatched++; $display("[TB] FAIL rst_food: got (%0d,%0d) expected (0,0)", food_x, food_y); end
    if (spawn_done !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_done: got %b expected 0", spawn_done); end
    if (fallback_used !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_fallback: got %b expected 0", fallback_used); end
    if (seg_addr !== 5'd0) begin mismatched++; $display("[TB] FAIL rst_addr: got %0d expected 0", seg_addr); end
    @(negedge VGA_clk); reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge VGA_clk); #1;
      compared++;
      if (spawn_done !== 1'b0 || busy !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL post_rst_idle: got done=%b busy=%b expected done=0 busy=0", spawn_done, busy);
      end
    end
  endtask

  task automatic test_random;
    int de, fx, fy, expEdge, ex, ey; bit fb, b0, v1, f1, efb, prevFb;
    bit wide;
    prevFb = 1'b0;
    for (int it = 0; it < 25; it++) begin
      wide = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < MAX_LEN; i++) begin
        memx[i] = $urandom_range(90, 170); memy[i] = $urandom_range(90, 170);
      end
      for (int e = 0; e <= MAXE; e++) begin
        rx[e] = wide ? $urandom_range(0, 1023) : $urandom_range(90, 170);
        ry[e] = wide ? $urandom_range(0, 511)  : $urandom_range(90, 170);
        ln[e] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 63);
      end
      predict(expEdge, ex, ey, efb);
      runSpawn(1'b1, de, fx, fy, fb, b0, v1, f1);
      compared += 4;
      if (de !== expEdge) begin mismatched++; $display("[TB] FAIL rand_edge[%0d]: got %0d expected %0d", it, de, expEdge); end
      if (fx !== ex || fy !== ey) begin mismatched++; $display("[TB] FAIL rand_food[%0d]: got (%0d,%0d) expected (%0d,%0d)", it, fx, fy, ex, ey); end
      if (fb !== efb) begin mismatched++; $display("[TB] FAIL rand_fallback[%0d]: got %b expected %b", it, fb, efb); end
      if (f1 !== prevFb || v1 !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL rand_e1[%0d]: got fb=%b validLow=%b expected fb=%b validLow=1", it, f1, v1, prevFb);
      end
      prevFb = efb;
      @(posedge VGA_clk); #1;
      compared++;
      if (spawn_done !== 1'b0 || busy !== 1'b0 || food_valid !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL rand_after[%0d]: got done=%b busy=%b valid=%b expected 0/0/1", it, spawn_done, busy, food_valid);
      end
      if (de < 0) break;
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    fillMem(600, 450);
    test_reset();
    test_len_zero();
    test_free_scan();
    test_clamp();
    test_retry();
    test_fallback();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
